// File: rtl/led_blink_if.sv
// Request/status bundle between a blink controller and led_blink_driver.
// The controller side drives the request and watches status and the pin;
// the driver side consumes the request and produces status and the pin.
interface led_blink_if #(
  parameter int COUNT_W = 4
) ();

  logic               start;
  logic [COUNT_W-1:0] blink_count;
  logic               cancel;
  logic               busy;
  logic               done;
  logic               led_out;

  modport master (
    output start,
    output blink_count,
    output cancel,
    input  busy,
    input  done,
    input  led_out
  );

  modport slave (
    input  start,
    input  blink_count,
    input  cancel,
    output busy,
    output done,
    output led_out
  );

endinterface

// File: rtl/led_blink_driver.sv
// LED blink sequencer: a one-cycle start request with a blink count turns into
// that many on/off periods on the LED pin, with busy while running and a
// one-cycle done on normal completion. cancel aborts silently; reset forces
// the LED dark immediately.
module led_blink_driver #(
  parameter int CLK_HZ         = 12_000_000,
  parameter int ON_MS          = 100,
  parameter int OFF_MS         = 100,
  parameter int COUNT_W        = 4,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  led_blink_if.slave bus
);

  // Period lengths in clock cycles; both are assumed to be at least 1.
  localparam int ON_CYCLES  = CLK_HZ / 1000 * ON_MS;
  localparam int OFF_CYCLES = CLK_HZ / 1000 * OFF_MS;
  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Terminal counts: the counter runs 0 .. N-1 inside a period.
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  localparam logic [COUNT_W-1:0] REM_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] REM_ZERO = '0;

  // Pin inversion applied to the registered lit state.
  localparam logic PIN_INV = (LED_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ON     = 2'd1,
    S_OFF    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               lit_q,       lit_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  // State, counters and registered outputs; reset darkens the LED at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      lit_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      lit_q       <= lit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // they appear registered in the same cycle as the state they describe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    lit_d       = lit_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        lit_d  = 1'b0;
        busy_d = 1'b0;
        // cancel in IDLE suppresses a simultaneous start.
        if (bus.start && !bus.cancel) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          if (bus.blink_count == REM_ZERO) begin
            // Zero blinks: acknowledge straight away with a done cycle.
            state_d     = S_FINISH;
            remaining_d = REM_ZERO;
            done_d      = 1'b1;
          end else begin
            state_d     = S_ON;
            remaining_d = bus.blink_count;
            lit_d       = 1'b1;
          end
        end
      end

      S_ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = S_OFF;
          lit_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          lit_d = 1'b1;
        end
      end

      S_OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          // Leave before remaining reaches zero so it never wraps.
          if (remaining_q == REM_ONE) begin
            state_d     = S_FINISH;
            remaining_d = REM_ZERO;
            lit_d       = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d     = S_ON;
            remaining_d = remaining_q - REM_ONE;
            lit_d       = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          lit_d = 1'b0;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        lit_d   = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        lit_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort from any active state: dark, idle, and no done pulse.
    if (bus.cancel && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      remaining_d = REM_ZERO;
      lit_d       = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.led_out = lit_q ^ PIN_INV;

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver with ON=3 cycles, OFF=2 cycles.
// dut_a uses an active-low pin, dut_b an active-high pin.
module tb_led_blink_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  led_blink_if #(.COUNT_W(4)) bus_a ();
  led_blink_if #(.COUNT_W(4)) bus_b ();

  led_blink_driver #(
    .CLK_HZ(1000), .ON_MS(3), .OFF_MS(2), .COUNT_W(4), .LED_ACTIVE_LOW(1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  led_blink_driver #(
    .CLK_HZ(1000), .ON_MS(3), .OFF_MS(2), .COUNT_W(4), .LED_ACTIVE_LOW(0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Two-blink run; optionally a second start (count 5) lands mid-run.
  task automatic run_two(input bit inject, input string tag);
    int dones;
    dones = 0;
    bus_a.start       = 1'b1;
    bus_a.blink_count = 4'd2;
    for (int i = 1; i <= 12; i++) begin
      if (inject && i == 3) begin
        bus_a.start       = 1'b1;
        bus_a.blink_count = 4'd5;
      end
      tick();
      bus_a.start = 1'b0;
      if (bus_a.done === 1'b1) dones++;
      chk({tag, "_led"},  bus_a.led_out, !((i >= 1 && i <= 3) || (i >= 6 && i <= 8)));
      chk({tag, "_busy"}, bus_a.busy,    (i <= 11));
      chk({tag, "_done"}, bus_a.done,    (i == 11));
    end
    chk({tag, "_done_count"}, dones, 1);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, pulses, width, bad_width;
    logic prev_led;

    bus_a.start = 1'b0; bus_a.blink_count = '0; bus_a.cancel = 1'b0;
    bus_b.start = 1'b0; bus_b.blink_count = '0; bus_b.cancel = 1'b0;

    // Reset with start held high.
    #1;
    rst_n = 1'b0;
    bus_a.start       = 1'b1;
    bus_a.blink_count = 4'd2;
    tick();
    tick();
    chk("rst_led",  bus_a.led_out, 1);
    chk("rst_busy", bus_a.busy,    0);
    chk("rst_done", bus_a.done,    0);
    chk("rst_led_b", bus_b.led_out, 0);
    rst_n       = 1'b1;
    bus_a.start = 1'b0;
    tick();
    chk("post_rst_led",  bus_a.led_out, 1);
    chk("post_rst_busy", bus_a.busy,    0);
    chk("post_rst_done", bus_a.done,    0);
    tick();

    // Two blinks.
    run_two(1'b0, "two");
    tick();

    // Zero-count request.
    bus_a.start       = 1'b1;
    bus_a.blink_count = 4'd0;
    tick();
    bus_a.start = 1'b0;
    chk("zero_busy1", bus_a.busy,    1);
    chk("zero_done1", bus_a.done,    1);
    chk("zero_led1",  bus_a.led_out, 1);
    tick();
    chk("zero_busy2", bus_a.busy,    0);
    chk("zero_done2", bus_a.done,    0);
    chk("zero_led2",  bus_a.led_out, 1);
    tick();

    // Start ignored while busy.
    run_two(1'b1, "ign");
    tick();

    // Cancel during the second ON period of a 3-blink run.
    bus_a.start       = 1'b1;
    bus_a.blink_count = 4'd3;
    for (int i = 1; i <= 6; i++) begin
      tick();
      bus_a.start = 1'b0;
    end
    chk("cxl_pre_led", bus_a.led_out, 0);
    bus_a.cancel = 1'b1;
    tick();
    bus_a.cancel = 1'b0;
    chk("cxl_led",  bus_a.led_out, 1);
    chk("cxl_busy", bus_a.busy,    0);
    chk("cxl_done", bus_a.done,    0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) done_cnt++;
    end
    chk("cxl_quiet", done_cnt, 0);

    // New one-blink start after the cancel.
    bus_a.start       = 1'b1;
    bus_a.blink_count = 4'd1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      bus_a.start = 1'b0;
      chk("one_led",  bus_a.led_out, !(i <= 3));
      chk("one_busy", bus_a.busy,    (i <= 6));
      chk("one_done", bus_a.done,    (i == 6));
    end

    // cancel and start together in IDLE: start is dropped.
    bus_a.start       = 1'b1;
    bus_a.cancel      = 1'b1;
    bus_a.blink_count = 4'd2;
    tick();
    bus_a.start  = 1'b0;
    bus_a.cancel = 1'b0;
    chk("both_busy", bus_a.busy,    0);
    chk("both_led",  bus_a.led_out, 1);
    tick();
    chk("both_busy2", bus_a.busy,   0);

    // Reset mid-sequence darkens the LED without a clock edge.
    bus_a.start       = 1'b1;
    bus_a.blink_count = 4'd3;
    tick();
    bus_a.start = 1'b0;
    tick();
    chk("mid_pre_led", bus_a.led_out, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_led",  bus_a.led_out, 1);
    chk("mid_async_busy", bus_a.busy,    0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_a.done === 1'b1) done_cnt++;
      if (bus_a.busy === 1'b1 || bus_a.led_out !== 1'b1) busy_cnt++;
    end
    chk("mid_no_done",  done_cnt, 0);
    chk("mid_idle",     busy_cnt, 0);

    // Maximum count on the active-high instance.
    chk("b_idle_led", bus_b.led_out, 0);
    bus_b.start       = 1'b1;
    bus_b.blink_count = 4'd15;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_at   = 0;
    pulses    = 0;
    width     = 0;
    bad_width = 0;
    prev_led  = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      tick();
      bus_b.start = 1'b0;
      if (c == 1) chk("b_first_led", bus_b.led_out, 1);
      if (bus_b.busy === 1'b1) busy_cnt++;
      if (bus_b.done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (bus_b.led_out === 1'b1) begin
        if (prev_led !== 1'b1) pulses++;
        width++;
      end else begin
        if (prev_led === 1'b1 && width != 3) bad_width++;
        width = 0;
      end
      prev_led = bus_b.led_out;
    end
    chk("max_busy_cycles", busy_cnt,  76);
    chk("max_done_count",  done_cnt,  1);
    chk("max_done_cycle",  done_at,   76);
    chk("max_pulses",      pulses,    15);
    chk("max_bad_widths",  bad_width, 0);
    chk("max_end_led",     bus_b.led_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_blink_driver.md
Name: led_blink_driver

Overview:
Output-side counterpart of the push-button input path: it turns a one-cycle request into human-visible LED activity on the board pin. A controller pulses `start` with a blink count. The block then drives `led_out` for that many on/off periods of millisecond scale, reports `busy` while running, and emits a one-cycle `done`. It runs in the 12 MHz system clock domain and drives an active-low LED pin.

Parameters:
CLK_HZ, 12_000_000, system clock frequency in Hz
ON_MS, 100, LED on-time per blink in ms
OFF_MS, 100, LED off-time per blink in ms
COUNT_W, 4, width of blink_count
LED_ACTIVE_LOW, 1, 1 = pin driven 0 when LED lit

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse, sampled on rising clk
blink_count  input  COUNT_W  number of blinks, sampled with start
cancel  input  1  abort current sequence, level sampled each cycle
busy  output  1  high while a sequence is in progress
done  output  1  one-cycle pulse at normal sequence completion
led_out  output  1  LED pin drive, polarity per LED_ACTIVE_LOW

Behaviour:
- Derived constants:
  - ON_CYCLES = CLK_HZ/1000*ON_MS.
  - OFF_CYCLES = CLK_HZ/1000*OFF_MS.
  - Both must be ≥1.
  - Period counter width = clog2(max(ON_CYCLES,OFF_CYCLES)+1).
- All outputs registered. Internal LED state `lit` maps to led_out = lit XOR LED_ACTIVE_LOW.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, lit=0 (led_out=1 with default), counters=0.
- FSM states: IDLE, ON, OFF, FINISH.
- IDLE:
  - start=1, blink_count≠0, cancel=0: latch remaining=blink_count, clear period counter, go to ON. Next cycle lit=1, busy=1.
  - start=1, blink_count=0: go to FINISH, no blink. Next cycle busy=1 and done=1 for that one cycle.
- ON: lit=1 for exactly ON_CYCLES cycles. On the last cycle: clear the counter, go to OFF.
- OFF: lit=0 for exactly OFF_CYCLES cycles. On the last cycle:
  - decrement remaining;
  - if remaining was 1, go to FINISH;
  - else go to ON.
- FINISH: one cycle with done=1 and busy=1, then IDLE with busy=0 and done=0.
- Latency: start edge k → lit at k+1. A sequence of N≥1 blinks keeps busy high for N*(ON_CYCLES+OFF_CYCLES)+1 cycles, the last of which carries done.
- start while not IDLE is ignored; blink_count is not re-sampled.
- cancel=1 in ON, OFF or FINISH: the next state is IDLE. lit=0, busy=0, done=0 (no done pulse), counters cleared.
- cancel and start both high in IDLE: cancel wins, start is dropped.
- blink_count at its max value (2^COUNT_W−1) must run fully; remaining has no wrap-around.
- Reset asserted mid-sequence: LED off immediately (asynchronous). After release the FSM is in IDLE; no done pulse.
- done is never high for more than one consecutive cycle.

Test Plan:
Use CLK_HZ=1000, ON_MS=3, OFF_MS=2 (ON_CYCLES=3, OFF_CYCLES=2), COUNT_W=4, LED_ACTIVE_LOW=1 unless noted.
1. Reset with start=1 held → led_out=1, busy=0, done=0 during reset and on the first cycle after release.
2. start with blink_count=2 at edge k → led_out=0 for k+1..k+3, 1 for k+4..k+5, 0 for k+6..k+8, 1 for k+9..k+10. done=1 only at k+11; busy high k+1..k+11.
3. blink_count=0 pulse at edge k → busy=1 and done=1 at k+1 only; led_out stays 1.
4. Second start during the sequence of scenario 2 (blink_count=5) → waveform identical to scenario 2, exactly one done.
5. cancel at the second ON period of a 3-blink run → led_out=1 and busy=0 on the next cycle. No done; a new start is then accepted normally.
6. blink_count=15 with LED_ACTIVE_LOW=0 → 15 high pulses of 3 cycles on led_out, busy for 76 cycles, a single done.
